// File: rtl/i2c_pkg.sv
// Shared types and constants for the WM8960-format I2C register-write target.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DEV     = 3'd1,
        ST_ACK_DEV = 3'd2,
        ST_HI      = 3'd3,
        ST_ACK_HI  = 3'd4,
        ST_LO      = 3'd5,
        ST_ACK_LO  = 3'd6,
        ST_IGNORE  = 3'd7
    } i2c_tgt_state_t;

    localparam logic [6:0] WM8960_DEV_ADDR = 7'h1A;
    localparam logic       I2C_RW_WRITE    = 1'b0;
    localparam logic [3:0] I2C_BYTE_BITS   = 4'd8;
    localparam logic [3:0] I2C_ACK_BIT     = 4'd9;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

endpackage

// File: rtl/wm8960_i2c_target_if.sv
// Register-write capture bus produced by the I2C target.
interface wm8960_i2c_target_if;
    logic       Wr_en;
    logic [6:0] Wr_addr;
    logic [8:0] Wr_data;
    logic       Busy;
    logic [7:0] Nack_cnt;

    modport master (output Wr_en, Wr_addr, Wr_data, Busy, Nack_cnt);
    modport slave  (input  Wr_en, Wr_addr, Wr_data, Busy, Nack_cnt);
endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser and glitch filter with registered edge, START and STOP pulses.
// Pin-to-event latency is SYNC_STAGES+FILT_LEN clocks; FILT_LEN must be at least 2.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_lvl,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    // bit 1 carries SCL, bit 0 carries SDA throughout
    logic [1:0]          sync_q [SYNC_STAGES];
    logic [1:0]          sync_d [SYNC_STAGES];
    logic [FILT_LEN-2:0] hist_q [2];
    logic [FILT_LEN-2:0] hist_d [2];
    logic [FILT_LEN-1:0] win_s;
    logic [1:0]          filt_q, filt_d;
    logic                scl_rise_q, scl_rise_d;
    logic                scl_fall_q, scl_fall_d;
    logic                start_q, start_d;
    logic                stop_q, stop_d;

    // Synchroniser shift and filter: a level is accepted only after FILT_LEN equal samples.
    always_comb begin
        sync_d[0] = {scl_in, sda_in};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        filt_d = filt_q;
        win_s  = '0;
        for (int b = 0; b < 2; b++) begin
            win_s     = {hist_q[b], sync_q[SYNC_STAGES-1][b]};
            hist_d[b] = win_s[FILT_LEN-2:0];
            if (&win_s) begin
                filt_d[b] = 1'b1;
            end else if (~|win_s) begin
                filt_d[b] = 1'b0;
            end else begin
                filt_d[b] = filt_q[b];
            end
        end
    end

    // Bus events are decoded from the next filtered levels so they align with the level flops.
    always_comb begin
        scl_rise_d = filt_d[1] & ~filt_q[1];
        scl_fall_d = ~filt_d[1] & filt_q[1];
        start_d    = filt_q[1] & filt_d[1] & filt_q[0] & ~filt_d[0];
        stop_d     = filt_q[1] & filt_d[1] & ~filt_q[0] & filt_d[0];
    end

    // Front-end state; reset to an idle (released-high) bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 2'b11;
            end
            hist_q[0]  <= '1;
            hist_q[1]  <= '1;
            filt_q     <= 2'b11;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            hist_q     <= hist_d;
            filt_q     <= filt_d;
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    assign sda_lvl   = filt_q[0];
    assign scl_rise  = scl_rise_q;
    assign scl_fall  = scl_fall_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;

endmodule

// File: rtl/wm8960_i2c_target.sv
// I2C target decoding WM8960 register writes {addr[6:0],d8} + d[7:0] into a one-cycle write strobe.
module wm8960_i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = WM8960_DEV_ADDR,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILT_LEN    = 3
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       i2c_sclk,
    inout  wire                        i2c_sdat,
    wm8960_i2c_target_if.master        wr_if
);

    logic sda_lvl_s, scl_rise_s, scl_fall_s, start_s, stop_s;
    logic byte_end_s, ack9_end_s, in_byte_s;

    i2c_tgt_state_t state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [6:0] addr_q, addr_d;
    logic       d8_q, d8_d;
    logic [7:0] d_lo_q, d_lo_d;
    logic       sda_low_q, sda_low_d;
    logic       busy_q, busy_d;
    logic [7:0] nack_q, nack_d;
    logic       wr_en_q, wr_en_d;
    logic [6:0] wr_addr_q, wr_addr_d;
    logic [8:0] wr_data_q, wr_data_d;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) u_bus_sync (
        .clk      (Clk),
        .rst      (Rst),
        .scl_in   (i2c_sclk),
        .sda_in   (i2c_sdat),
        .sda_lvl  (sda_lvl_s),
        .scl_rise (scl_rise_s),
        .scl_fall (scl_fall_s),
        .start_det(start_s),
        .stop_det (stop_s)
    );

    assign byte_end_s = scl_fall_s && (bit_cnt_q == I2C_BYTE_BITS);
    assign ack9_end_s = scl_fall_s && (bit_cnt_q == I2C_ACK_BIT);
    assign in_byte_s  = (state_q == ST_DEV) || (state_q == ST_HI) ||
                        (state_q == ST_LO)  || (state_q == ST_IGNORE);

    // Next-state logic; STOP beats START, and both beat bit sampling in the same cycle.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        d8_d      = d8_q;
        d_lo_d    = d_lo_q;
        sda_low_d = sda_low_q;
        busy_d    = busy_q;
        nack_d    = nack_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (stop_s) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 4'd0;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else if (start_s) begin
            state_d   = ST_DEV;
            bit_cnt_d = 4'd0;
            sda_low_d = 1'b0;
        end else if (in_byte_s && scl_rise_s) begin
            shift_d   = {shift_q[6:0], sda_lvl_s};
            bit_cnt_d = (bit_cnt_q == I2C_ACK_BIT) ? bit_cnt_q : bit_cnt_q + 4'd1;
        end else begin
            case (state_q)
                ST_DEV: begin
                    // a mismatch keeps the count at 8 so IGNORE skips the NACK clock
                    if (byte_end_s && (shift_q == {DEV_ADDR, I2C_RW_WRITE})) begin
                        state_d   = ST_ACK_DEV;
                        sda_low_d = 1'b1;
                        busy_d    = 1'b1;
                    end else if (byte_end_s) begin
                        state_d = ST_IGNORE;
                        busy_d  = 1'b0;
                        nack_d  = sat_inc8(nack_q);
                    end else begin
                        state_d = ST_DEV;
                    end
                end
                ST_HI: begin
                    if (byte_end_s) begin
                        addr_d    = shift_q[7:1];
                        d8_d      = shift_q[0];
                        state_d   = ST_ACK_HI;
                        sda_low_d = 1'b1;
                    end else begin
                        state_d = ST_HI;
                    end
                end
                ST_LO: begin
                    if (byte_end_s) begin
                        d_lo_d    = shift_q;
                        state_d   = ST_ACK_LO;
                        sda_low_d = 1'b1;
                    end else begin
                        state_d = ST_LO;
                    end
                end
                ST_ACK_DEV, ST_ACK_HI, ST_ACK_LO: begin
                    if (scl_fall_s) begin
                        sda_low_d = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = (state_q == ST_ACK_DEV) ? ST_HI :
                                    (state_q == ST_ACK_HI)  ? ST_LO : ST_IGNORE;
                        wr_en_d   = (state_q == ST_ACK_LO);
                        wr_addr_d = (state_q == ST_ACK_LO) ? addr_q : wr_addr_q;
                        wr_data_d = (state_q == ST_ACK_LO) ? {d8_q, d_lo_q} : wr_data_q;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_IGNORE: begin
                    sda_low_d = 1'b0;
                    if (byte_end_s) begin
                        nack_d = sat_inc8(nack_q);
                    end else if (ack9_end_s) begin
                        bit_cnt_d = 4'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d   = ST_IDLE;
                    sda_low_d = 1'b0;
                end
            endcase
        end
    end

    // Protocol state and registered outputs; reset releases SDA asynchronously.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'd0;
            addr_q    <= 7'd0;
            d8_q      <= 1'b0;
            d_lo_q    <= 8'd0;
            sda_low_q <= 1'b0;
            busy_q    <= 1'b0;
            nack_q    <= 8'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 7'd0;
            wr_data_q <= 9'd0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            d8_q      <= d8_d;
            d_lo_q    <= d_lo_d;
            sda_low_q <= sda_low_d;
            busy_q    <= busy_d;
            nack_q    <= nack_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign i2c_sdat       = sda_low_q ? 1'b0 : 1'bz;
    assign wr_if.Wr_en    = wr_en_q;
    assign wr_if.Wr_addr  = wr_addr_q;
    assign wr_if.Wr_data  = wr_data_q;
    assign wr_if.Busy     = busy_q;
    assign wr_if.Nack_cnt = nack_q;

endmodule

// File: tb/tb_wm8960_i2c_target.sv
// Directed bench: bit-banged I2C master with pull-up drives WM8960 writes into the target.
module tb_wm8960_i2c_target;

    localparam int Q = 10;  // clocks per quarter SCL period

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl = 1'b1;
    logic tb_sda_low = 1'b0;
    wire  sda_bus;

    pullup (sda_bus);
    assign sda_bus = tb_sda_low ? 1'b0 : 1'bz;

    wm8960_i2c_target_if wr_if ();

    wm8960_i2c_target #(
        .DEV_ADDR   (7'h1A),
        .SYNC_STAGES(2),
        .FILT_LEN   (3)
    ) dut (
        .Clk     (clk),
        .Rst     (rst),
        .i2c_sclk(scl),
        .i2c_sdat(sda_bus),
        .wr_if   (wr_if)
    );

    always #10 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         wr_cnt   = 0;
    int         drv_cnt  = 0;
    int         drv_base = 0;
    logic [6:0] cap_addr = 7'd0;
    logic [8:0] cap_data = 9'd0;
    logic       acked;

    // every high cycle counts, so a stretched strobe shows up as an extra write
    always @(posedge clk) begin
        if (wr_if.Wr_en) begin
            wr_cnt   <= wr_cnt + 1;
            cap_addr <= wr_if.Wr_addr;
            cap_data <= wr_if.Wr_data;
        end
    end

    // cycles where SDA is low although the master has released it
    always @(negedge clk) begin
        if (!tb_sda_low && (sda_bus == 1'b0)) drv_cnt <= drv_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        tb_sda_low = 1'b1;
        clks(Q);
        scl = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        clks(Q);
        tb_sda_low = ~b;
        clks(Q);
        scl = 1'b1;
        clks(2 * Q);
        scl = 1'b0;
    endtask

    task automatic ack_bit(output logic a);
        clks(Q);
        tb_sda_low = 1'b0;
        clks(Q);
        scl = 1'b1;
        clks(Q);
        a = (sda_bus == 1'b0);
        clks(Q);
        scl = 1'b0;
    endtask

    task automatic send_chk(input string tag, input logic [7:0] b, input logic exp_ack);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        ack_bit(a);
        chk(tag, {31'd0, a}, {31'd0, exp_ack});
    endtask

    task automatic bus_rstart();
        clks(Q);
        tb_sda_low = 1'b0;
        clks(Q);
        scl = 1'b1;
        clks(Q);
        tb_sda_low = 1'b1;
        clks(Q);
        scl = 1'b0;
    endtask

    task automatic bus_stop();
        clks(Q);
        tb_sda_low = 1'b1;
        clks(Q);
        scl = 1'b1;
        clks(Q);
        tb_sda_low = 1'b0;
        clks(4 * Q);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset values
        clks(5);
        chk("rst_wr_en", {31'd0, wr_if.Wr_en}, 32'd0);
        chk("rst_addr", {25'd0, wr_if.Wr_addr}, 32'd0);
        chk("rst_data", {23'd0, wr_if.Wr_data}, 32'd0);
        chk("rst_busy", {31'd0, wr_if.Busy}, 32'd0);
        chk("rst_nack", {24'd0, wr_if.Nack_cnt}, 32'd0);
        chk("rst_sda", {31'd0, sda_bus}, 32'd1);
        rst = 1'b0;
        clks(4 * Q);

        // 1: reg 0x07 = 0x00A
        bus_start();
        send_chk("t1_ack_dev", 8'h34, 1'b1);
        chk("t1_busy", {31'd0, wr_if.Busy}, 32'd1);
        send_chk("t1_ack_hi", 8'h0E, 1'b1);
        send_chk("t1_ack_lo", 8'h0A, 1'b1);
        bus_stop();
        chk("t1_wr_cnt", wr_cnt, 32'd1);
        chk("t1_addr", {25'd0, cap_addr}, 32'h07);
        chk("t1_data", {23'd0, cap_data}, 32'h00A);

        // 2: reg 0x0F = 0x100 (bit 8 set)
        bus_start();
        send_chk("t2_ack_dev", 8'h34, 1'b1);
        send_chk("t2_ack_hi", 8'h1F, 1'b1);
        send_chk("t2_ack_lo", 8'h00, 1'b1);
        chk("t2_busy_pre", {31'd0, wr_if.Busy}, 32'd1);
        bus_stop();
        chk("t2_busy_post", {31'd0, wr_if.Busy}, 32'd0);
        chk("t2_wr_cnt", wr_cnt, 32'd2);
        chk("t2_addr", {25'd0, wr_if.Wr_addr}, 32'h0F);
        chk("t2_data", {23'd0, wr_if.Wr_data}, 32'h100);

        // 3: wrong address, then read request
        drv_base = drv_cnt;
        bus_start();
        send_chk("t3_nack_36", 8'h36, 1'b0);
        chk("t3_busy", {31'd0, wr_if.Busy}, 32'd0);
        bus_stop();
        bus_start();
        send_chk("t3_nack_35", 8'h35, 1'b0);
        bus_stop();
        chk("t3_nack_cnt", {24'd0, wr_if.Nack_cnt}, 32'd2);
        chk("t3_wr_cnt", wr_cnt, 32'd2);
        chk("t3_sda_drv", drv_cnt - drv_base, 32'd0);

        // 4: partial write cut by repeated START
        bus_start();
        send_chk("t4_ack_dev0", 8'h34, 1'b1);
        send_chk("t4_ack_hi0", 8'h0E, 1'b1);
        bus_rstart();
        send_chk("t4_ack_dev1", 8'h34, 1'b1);
        chk("t4_busy", {31'd0, wr_if.Busy}, 32'd1);
        send_chk("t4_ack_hi1", 8'h12, 1'b1);
        send_chk("t4_ack_lo1", 8'h34, 1'b1);
        bus_stop();
        chk("t4_wr_cnt", wr_cnt, 32'd3);
        chk("t4_addr", {25'd0, cap_addr}, 32'h09);
        chk("t4_data", {23'd0, cap_data}, 32'h034);

        // 5: overflow byte NACKed, then STOP after two bytes
        bus_start();
        send_chk("t5_ack_dev", 8'h34, 1'b1);
        send_chk("t5_ack_hi", 8'h0E, 1'b1);
        send_chk("t5_ack_lo", 8'h0A, 1'b1);
        send_chk("t5_nack_ovf", 8'h55, 1'b0);
        bus_stop();
        chk("t5_wr_cnt", wr_cnt, 32'd4);
        chk("t5_nack_cnt", {24'd0, wr_if.Nack_cnt}, 32'd3);
        bus_start();
        send_chk("t5_ack_dev2", 8'h34, 1'b1);
        send_chk("t5_ack_hi2", 8'h1F, 1'b1);
        bus_stop();
        chk("t5_partial_cnt", wr_cnt, 32'd4);
        chk("t5_data_held", {23'd0, wr_if.Wr_data}, 32'h00A);

        // 6: reset while the target drives the ACK_HI bit
        bus_start();
        send_chk("t6_ack_dev", 8'h34, 1'b1);
        for (int i = 7; i >= 0; i--) send_bit(i[3:0] inside {4'd1, 4'd2, 4'd3});
        clks(Q);
        tb_sda_low = 1'b0;
        clks(Q);
        scl = 1'b1;
        clks(Q);
        chk("t6_ack_drv", {31'd0, sda_bus}, 32'd0);
        #3 rst = 1'b1;
        #1;
        chk("t6_sda_rel", {31'd0, sda_bus}, 32'd1);
        chk("t6_busy", {31'd0, wr_if.Busy}, 32'd0);
        chk("t6_nack", {24'd0, wr_if.Nack_cnt}, 32'd0);
        chk("t6_wr_addr", {25'd0, wr_if.Wr_addr}, 32'd0);
        chk("t6_wr_data", {23'd0, wr_if.Wr_data}, 32'd0);
        clks(Q);
        scl = 1'b0;
        clks(Q);
        scl = 1'b1;
        clks(Q);
        rst = 1'b0;
        clks(4 * Q);
        bus_start();
        send_chk("t6_ack_dev2", 8'h34, 1'b1);
        send_chk("t6_ack_hi2", 8'h0E, 1'b1);
        send_chk("t6_ack_lo2", 8'h0A, 1'b1);
        bus_stop();
        chk("t6_wr_cnt", wr_cnt, 32'd5);
        chk("t6_addr", {25'd0, cap_addr}, 32'h07);
        chk("t6_data", {23'd0, cap_data}, 32'h00A);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
